// File: rtl/audio_voice_scheduler.sv
// Four-voice hit-sound scheduler: one frame per sample tick time-shares
// the single-port clip ROM, mixes active voices and saturates to 8 bits.
module audio_voice_scheduler #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SAMPLE_HZ = 8000,
  parameter int ADDR_W    = 11,
  parameter int CLIP_LEN  = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        trigger,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        sample_out,
  output logic              sample_valid,
  output logic [3:0]        voice_active
);

  localparam int DIV = CLK_HZ / SAMPLE_HZ;
  localparam int DW  = $clog2(DIV);
  localparam int PW  = $clog2(CLIP_LEN);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    ACC,
    OUT
  } state_t;

  state_t             state;
  logic [DW-1:0]      div;
  logic               tick;
  logic [1:0]         v;
  logic signed [9:0]  acc;
  logic               fetch;
  logic [PW-1:0]      pos [4];
  logic [7:0]         clamped;

  assign tick = (div == DW'(DIV - 1));

  always_comb begin
    clamped = {~acc[7], acc[6:0]};
    if (acc > 10'sd127) clamped = 8'hFF;
    else if (acc < -10'sd128) clamped = 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      div          <= '0;
      v            <= '0;
      acc          <= '0;
      fetch        <= 1'b0;
      rom_addr     <= '0;
      sample_out   <= 8'h80;
      sample_valid <= 1'b0;
      voice_active <= '0;
      for (int i = 0; i < 4; i++) pos[i] <= '0;
    end else begin
      sample_valid <= 1'b0;
      div <= tick ? '0 : div + DW'(1);
      unique case (state)
        IDLE: begin
          acc <= '0;
          v   <= '0;
          if (tick) state <= ADDR;
        end
        ADDR: begin
          fetch <= voice_active[v];
          if (voice_active[v])
            rom_addr <= ADDR_W'(int'(v) * CLIP_LEN + int'(pos[v]));
          state <= WAIT;
        end
        WAIT: state <= ACC;
        ACC: begin
          if (fetch) begin
            acc <= acc + $signed({2'b00, rom_data}) - 10'sd128;
            if (pos[v] == PW'(CLIP_LEN - 1)) begin
              pos[v]          <= '0;
              voice_active[v] <= 1'b0;
            end else begin
              pos[v] <= pos[v] + PW'(1);
            end
          end
          v     <= v + 2'd1;
          state <= (v == 2'd3) ? OUT : ADDR;
        end
        OUT: begin
          sample_out   <= clamped;
          sample_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // a trigger overrides the ACC-slot update of the same voice
      for (int i = 0; i < 4; i++) begin
        if (trigger[i]) begin
          voice_active[i] <= 1'b1;
          pos[i]          <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_voice_scheduler.sv
// Directed bench for audio_voice_scheduler with DIV=16 and a
// behavioural ROM with one-cycle registered read.
module tb_audio_voice_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  trigger = '0;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  sample_out;
  logic        sample_valid;
  logic [3:0]  voice_active;

  logic [7:0]  rom [2048];
  int          vecs = 0;
  int          errs = 0;
  int          pcnt = 0;
  int          r = 0;

  audio_voice_scheduler #(
    .CLK_HZ(128000),
    .SAMPLE_HZ(8000),
    .ADDR_W(11),
    .CLIP_LEN(512)
  ) dut (
    .clk(clk),
    .reset(reset),
    .trigger(trigger),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .sample_out(sample_out),
    .sample_valid(sample_valid),
    .voice_active(voice_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pcnt <= pcnt + 1;
    rom_data <= rom[rom_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // valid is due 14 clk after each tick; ticks fall on cycles 15+16k
  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_valid && n < 40);
    if (!sample_valid) begin
      vecs++;
      errs++;
      $error("FAIL valid_timeout observed 0 expected 1");
    end else begin
      chk("tick_to_valid", 32'((pcnt - r - 29) % 16), 0);
    end
  endtask

  task automatic fill_rom(input int mode, input logic [7:0] val);
    for (int i = 0; i < 2048; i++)
      rom[i] = (mode == 0) ? 8'(i) : val;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sample", sample_out, 8'h80);
    chk("rst_valid", sample_valid, 0);
    chk("rst_active", voice_active, 0);
    chk("rst_addr", rom_addr, 0);
    reset = 1'b0;
    r = pcnt;
  endtask

  task automatic pulse(input logic [3:0] t);
    trigger = t;
    @(negedge clk);
    trigger = '0;
  endtask

  initial begin
    fill_rom(0, 8'h00);

    // 1: idle frames
    do_reset();
    wait_valid();
    chk("idle_first_cycle", pcnt - r, 29);
    chk("idle_sample", sample_out, 8'h80);
    chk("idle_active", voice_active, 0);
    chk("idle_addr", rom_addr, 0);
    @(negedge clk);
    chk("valid_width", sample_valid, 0);
    wait_valid();
    chk("idle_second_cycle", pcnt - r, 45);
    chk("idle_sample2", sample_out, 8'h80);

    // 2: single voice ramp across whole clip
    pulse(4'b0001);
    for (int k = 0; k < 512; k++) begin
      wait_valid();
      chk("ramp_sample", sample_out, 32'(k % 256));
      chk("ramp_addr", rom_addr, 32'(k));
      chk("ramp_active", voice_active, (k == 511) ? 0 : 1);
    end
    wait_valid();
    chk("ramp_end_sample", sample_out, 8'h80);
    chk("ramp_end_active", voice_active, 0);
    chk("ramp_end_addr", rom_addr, 511);

    // 3: saturation
    fill_rom(1, 8'hFF);
    pulse(4'b1111);
    wait_valid();
    chk("sat_hi_sample", sample_out, 8'hFF);
    chk("sat_hi_addr", rom_addr, 1536);
    chk("sat_hi_active", voice_active, 4'hF);
    fill_rom(1, 8'h00);
    wait_valid();
    chk("sat_lo_sample", sample_out, 8'h00);
    chk("sat_lo_addr", rom_addr, 1537);

    do_reset();
    fill_rom(1, 8'hA0);
    wait_valid();
    pulse(4'b0011);
    wait_valid();
    chk("two_voice_sample", sample_out, 8'hC0);
    chk("two_voice_active", voice_active, 4'b0011);

    // 5: reset during voice 2 WAIT (cycle 24 = next tick + 8)
    trigger = 4'b0111;
    @(negedge clk);
    trigger = '0;
    repeat (9) @(negedge clk);
    chk("pre_abort_active", voice_active, 4'b0111);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_active", voice_active, 0);
    chk("abort_sample", sample_out, 8'h80);
    chk("abort_valid", sample_valid, 0);
    chk("abort_addr", rom_addr, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    r = pcnt;
    fill_rom(0, 8'h00);
    wait_valid();
    chk("post_abort_cycle", pcnt - r, 29);
    chk("post_abort_sample", sample_out, 8'h80);

    // 4: retrigger voice 1 in its ACC slot at pos 100
    pulse(4'b0010);
    repeat (100) wait_valid();
    chk("v1_pos99_sample", sample_out, 8'h63);
    chk("v1_pos99_addr", rom_addr, 611);
    repeat (8) @(negedge clk);
    chk("v1_acc_addr", rom_addr, 612);
    pulse(4'b0010);
    wait_valid();
    chk("v1_retrig_sample", sample_out, 8'h64);
    chk("v1_retrig_active", voice_active, 4'b0010);
    wait_valid();
    chk("v1_restart_addr", rom_addr, 512);
    chk("v1_restart_sample", sample_out, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
